regbus_arbiter: RTL and testbench

Two-master round-robin arbiter for the shared 8-bit-address / 16-bit-data slot register bank. Master 0 is the SPI slave front end (host transactions: output, input, direction, int-mask and int-clear registers); master 1 is an on-chip sequencer. It serialises accesses into one single-outstanding slave transaction and returns write acknowledge or read data to the granted master. A timeout guards against a slave that never acknowledges.

---
 rtl/regbus_arbiter_if.sv | 58 +++++
 rtl/regbus_arbiter.sv | 138 +++++++++++++
 tb/tb_regbus_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regbus_arbiter_if.sv
// Bus bundle for the two-master slot-register arbiter: both master request/ack
// channels, the single slave channel and the arbiter status/debug outputs.
interface regbus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_lock;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;

  logic              owner;
  logic              busy;
  logic              timeout;
  logic [1:0]        fsm_state;

  // Handshake: mX_req is held (with we/addr/wdata/lock stable) until the
  // one-cycle mX_ack pulse, then dropped; s_req is a one-cycle strobe answered
  // by a one-cycle s_ack carrying s_rdata; only one slave access is outstanding.

  // Arbiter view: accepts master requests and slave responses.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  s_ack, s_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output s_req, s_we, s_addr, s_wdata,
    output owner, busy, timeout, fsm_state
  );

  // Environment view: the two masters plus the register-bank slave.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output s_ack, s_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  s_req, s_we, s_addr, s_wdata,
    input  owner, busy, timeout, fsm_state
  );
endinterface

// File: rtl/regbus_arbiter.sv
// Two-master round-robin arbiter serialising accesses to the slot register bank,
// with slave timeout. Define REGBUS_ARB_LOCK_EN to enable master bus locking.
module regbus_arbiter #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  regbus_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, next_state;
  logic              grant_valid, grant, capture, expire;
  logic              owner_q, last_grant_q, timeout_q, lock_q;
  logic              s_we_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q, m0_rdata_q, m1_rdata_q, done_data;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant       = 1'b0;
    capture     = 1'b0;
    expire      = 1'b0;
    case (state)
      IDLE: begin
        if (lock_q) begin
          // A locked owner keeps the bus; the other master waits.
          grant       = owner_q;
          grant_valid = owner_q ? bus.m1_req : bus.m0_req;
        end else begin
          grant_valid = bus.m0_req | bus.m1_req;
          grant       = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
        end
        if (grant_valid) next_state = ISSUE;
      end
      ISSUE: begin
        if (bus.s_ack) begin
          capture    = 1'b1;
          next_state = DONE;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.s_ack) begin
          capture    = 1'b1;
          next_state = DONE;
        end else if (cnt_q == CNT_LAST) begin
          expire     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign done_data = capture ? bus.s_rdata : ERR_DATA;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timeout_q    <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      cnt_q        <= '0;
    end else begin
      timeout_q <= expire;
      if (grant_valid) begin
        owner_q   <= grant;
        s_we_q    <= grant ? bus.m1_we    : bus.m0_we;
        s_addr_q  <= grant ? bus.m1_addr  : bus.m0_addr;
        s_wdata_q <= grant ? bus.m1_wdata : bus.m0_wdata;
      end
      // Counter saturates at its terminal value rather than wrapping.
      if (state == ISSUE)
        cnt_q <= '0;
      else if (state == WAIT && cnt_q != CNT_LAST)
        cnt_q <= cnt_q + CNT_W'(1);
      if (capture || expire) begin
        if (owner_q) m1_rdata_q <= done_data;
        else         m0_rdata_q <= done_data;
      end
      if (state == DONE) last_grant_q <= owner_q;
    end
  end

`ifdef REGBUS_ARB_LOCK_EN
  // Lock is sampled on entry to DONE; a forced completion always releases it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      lock_q <= 1'b0;
    else if (expire)
      lock_q <= 1'b0;
    else if (capture)
      lock_q <= owner_q ? bus.m1_lock : bus.m0_lock;
  end
`else
  logic unused_lock;
  assign lock_q      = 1'b0;
  assign unused_lock = bus.m0_lock ^ bus.m1_lock;
`endif

  assign bus.s_req     = (state == ISSUE);
  assign bus.s_we      = s_we_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.m0_ack    = (state == DONE) && !owner_q;
  assign bus.m1_ack    = (state == DONE) &&  owner_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state != IDLE);
  assign bus.timeout   = timeout_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: expected acks/read data are queued as each
// request is driven and compared when the arbiter pulses an ack.
module tb_regbus_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regbus_arbiter dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_lock = 1'b0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_lock = 1'b0;
    bus.s_ack  = 1'b0; bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive(input logic m, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic lk);
    if (!m) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_lock = lk;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_lock = lk;
    end
  endtask

  // Slave model: wait for the strobe, stall wait_n cycles, then ack with rd.
  task automatic serve(input string tag, input logic exp_owner, input logic [AW-1:0] exp_addr,
                       input int wait_n, input logic [DW-1:0] rd);
    int n;
    n = 0;
    while (bus.s_req !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "_s_req"}, {31'd0, bus.s_req}, 32'd1);
    chk({tag, "_owner"}, {31'd0, bus.owner}, {31'd0, exp_owner});
    chk({tag, "_s_addr"}, {24'd0, bus.s_addr}, {24'd0, exp_addr});
    repeat (wait_n) tick();
    bus.s_ack = 1'b1;
    bus.s_rdata = rd;
    tick();
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
  endtask

  task automatic wait_ack(input string tag, input int budget, output int n);
    logic [DW+1:0] exp;
    logic [DW+1:0] obs;
    n = 0;
    while (!(bus.m0_ack || bus.m1_ack) && n < budget) begin
      tick();
      n++;
    end
    if (!(bus.m0_ack || bus.m1_ack)) begin
      checks++;
      errors++;
      $error("FAIL %s_ack: observed no ack, expected ack within %0d cycles", tag, budget);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed ack, expected none queued", tag);
    end else begin
      exp = exp_q.pop_front();
      obs = {bus.m1_ack, bus.m0_ack, (bus.m1_ack ? bus.m1_rdata : bus.m0_rdata)};
      chk({tag, "_ack_data"}, {14'd0, obs}, {14'd0, exp});
      if (bus.m0_ack) bus.m0_req = 1'b0;
      if (bus.m1_ack) bus.m1_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    idle_inputs();
    do_reset();

    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_owner", {31'd0, bus.owner}, 32'd0);
    chk("reset_state", {30'd0, bus.fsm_state}, 32'd0);

    // Simultaneous requests straight out of reset: m0, then m1, then m0 again.
    drive(1'b0, 1'b1, 8'h10, 16'h1111, 1'b0);
    drive(1'b1, 1'b1, 8'h20, 16'h2222, 1'b0);
    exp_q.push_back({2'b01, 16'hA0A0});
    exp_q.push_back({2'b10, 16'hB0B0});
    serve("tie1", 1'b0, 8'h10, 0, 16'hA0A0);
    wait_ack("tie1", 4, n);
    serve("tie2", 1'b1, 8'h20, 1, 16'hB0B0);
    wait_ack("tie2", 4, n);
    tick();
    drive(1'b0, 1'b0, 8'h11, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 8'h21, 16'h0, 1'b0);
    exp_q.push_back({2'b01, 16'hC0C0});
    exp_q.push_back({2'b10, 16'hD0D0});
    serve("tie3", 1'b0, 8'h11, 0, 16'hC0C0);
    wait_ack("tie3", 4, n);
    serve("tie4", 1'b1, 8'h21, 0, 16'hD0D0);
    wait_ack("tie4", 4, n);

    // Minimum latency write: strobe at cycle 1, ack at cycle 2, idle at cycle 3.
    tick();
    drive(1'b0, 1'b1, 8'h00, 16'hAAAA, 1'b0);
    exp_q.push_back({2'b01, 16'h1234});
    tick();
    chk("wr_s_req", {31'd0, bus.s_req}, 32'd1);
    chk("wr_s_we", {31'd0, bus.s_we}, 32'd1);
    chk("wr_s_addr", {24'd0, bus.s_addr}, 32'h00);
    chk("wr_s_wdata", {16'd0, bus.s_wdata}, 32'hAAAA);
    bus.s_ack = 1'b1;
    bus.s_rdata = 16'h1234;
    tick();
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    wait_ack("wr_min", 0, n);
    tick();
    chk("wr_busy_c3", {31'd0, bus.busy}, 32'd0);

    // m1 read with slave stall.
    drive(1'b1, 1'b0, 8'h81, 16'h0, 1'b0);
    exp_q.push_back({2'b10, 16'h5555});
    serve("rd_wait", 1'b1, 8'h81, 5, 16'h5555);
    chk("rd_wait_s_we", {31'd0, bus.s_we}, 32'd0);
    wait_ack("rd_wait", 4, n);
    tick();

    // Slave never answers: forced completion at cycle TIMEOUT+2.
    drive(1'b0, 1'b0, 8'h3C, 16'h0, 1'b0);
    exp_q.push_back({2'b01, 16'hDEAD});
    wait_ack("tmo", 200, n);
    chk("tmo_cycle", n, 32'd66);
    chk("tmo_pulse", {31'd0, bus.timeout}, 32'd1);
    tick();
    chk("tmo_clear", {31'd0, bus.timeout}, 32'd0);

    drive(1'b1, 1'b1, 8'h42, 16'h0F0F, 1'b0);
    exp_q.push_back({2'b10, 16'h4321});
    serve("post_tmo", 1'b1, 8'h42, 2, 16'h4321);
    wait_ack("post_tmo", 4, n);
    chk("post_tmo_flag", {31'd0, bus.timeout}, 32'd0);
    tick();

    // Asynchronous reset in the middle of WAIT abandons the access.
    drive(1'b1, 1'b0, 8'h44, 16'h0, 1'b0);
    n = 0;
    while (bus.s_req !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_state", {30'd0, bus.fsm_state}, 32'd0);
    chk("rst_owner", {31'd0, bus.owner}, 32'd0);
    chk("rst_s_addr", {24'd0, bus.s_addr}, 32'd0);
    chk("rst_m1_rdata", {16'd0, bus.m1_rdata}, 32'd0);
    chk("rst_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({2'b10, 16'h7777});
    serve("re_issue", 1'b1, 8'h44, 0, 16'h7777);
    wait_ack("re_issue", 4, n);

    // Locked read by m0 while m1 waits.
    do_reset();
    drive(1'b0, 1'b0, 8'h50, 16'h0, 1'b1);
    drive(1'b1, 1'b1, 8'h60, 16'h6666, 1'b0);
    exp_q.push_back({2'b01, 16'h5050});
    serve("lk_first", 1'b0, 8'h50, 0, 16'h5050);
    wait_ack("lk_first", 4, n);
    tick();
    drive(1'b0, 1'b1, 8'h51, 16'h5151, 1'b0);
`ifdef REGBUS_ARB_LOCK_EN
    exp_q.push_back({2'b01, 16'hA5A5});
    serve("lk_hold", 1'b0, 8'h51, 0, 16'hA5A5);
    wait_ack("lk_hold", 4, n);
    exp_q.push_back({2'b10, 16'hB6B6});
    serve("lk_release", 1'b1, 8'h60, 0, 16'hB6B6);
    wait_ack("lk_release", 4, n);
`else
    exp_q.push_back({2'b10, 16'hB6B6});
    serve("no_lock_m1", 1'b1, 8'h60, 0, 16'hB6B6);
    wait_ack("no_lock_m1", 4, n);
    exp_q.push_back({2'b01, 16'hA5A5});
    serve("no_lock_m0", 1'b0, 8'h51, 0, 16'hA5A5);
    wait_ack("no_lock_m0", 4, n);
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
